// File: rtl/ascon_pkg.sv
// Shared constants for the Ascon-Hash message feeder and the core it drives.
package ascon_pkg;

  localparam int unsigned RATE_BYTES       = 8;
  localparam logic [7:0]  PAD_BYTE_DEFAULT = 8'h80;

  // Core controller state encodings, as reported on core_state
  typedef enum logic [2:0] {
    CORE_INIT    = 3'd0,
    CORE_IDLE    = 3'd1,
    CORE_ABSORB  = 3'd2,
    CORE_PERMUTE = 3'd3,
    CORE_SQUEEZE = 3'd4
  } core_state_t;

  typedef logic [2:0] feeder_state_t;

  localparam feeder_state_t S_COLLECT   = 3'd0;
  localparam feeder_state_t S_PADBLK    = 3'd1;
  localparam feeder_state_t S_WAIT_IDLE = 3'd2;
  localparam feeder_state_t S_OFFER     = 3'd3;
  localparam feeder_state_t S_WAIT_PERM = 3'd4;
  localparam feeder_state_t S_WAIT_HASH = 3'd5;

endpackage

// File: rtl/ascon_byte_packer.sv
// Inserts one host byte into a 64-bit rate block and applies 10* padding on the last byte.
module ascon_byte_packer
  import ascon_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
  input  logic [63:0] blk,
  input  logic [2:0]  cnt,
  input  logic [7:0]  data,
  input  logic        last,
  input  logic        empty,
  output logic [63:0] blk_next,
  output logic        done,
  output logic        final_blk,
  output logic        pad_pending
);

  logic [0:7][7:0] lanes;
  logic [3:0]      pos;

  // Lane 0 is the most significant byte, so the first message byte lands in [63:56]
  always_comb begin
    lanes = blk;
    pos   = {1'b0, cnt};
    if (last && empty) begin
      lanes    = '0;
      lanes[0] = PAD_BYTE;
    end else begin
      for (int unsigned i = 0; i < RATE_BYTES; i++) begin
        if (4'(i) == pos) begin
          lanes[3'(i)] = data;
        end else if (last && (4'(i) == pos + 4'd1)) begin
          lanes[3'(i)] = PAD_BYTE;
        end else if (last && (4'(i) > pos + 4'd1)) begin
          lanes[3'(i)] = '0;
        end
      end
    end
    blk_next = lanes;
  end

  // A last byte in lane 7 leaves no room for the marker: a separate padding block follows
  always_comb begin
    done        = last || (cnt == 3'd7);
    final_blk   = last && (empty || (cnt != 3'd7));
    pad_pending = last && !empty && (cnt == 3'd7);
  end

endmodule

// File: rtl/ascon_msg_feeder.sv
// Packs a host byte stream into padded rate blocks and hands them to the Ascon-Hash core.
module ascon_msg_feeder
  import ascon_pkg::*;
#(
  parameter int unsigned WDOG_CYCLES = 1024,
  parameter logic [7:0]  PAD_BYTE    = PAD_BYTE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  input  logic        in_empty,
  output logic [63:0] blk_data,
  output logic        msg_start,
  output logic        msg_last,
  input  logic        absorb_done,
  input  logic        permutation_done,
  input  logic [2:0]  core_state,
  output logic        msg_done,
  output logic [15:0] blk_count,
  output logic        err
);

  feeder_state_t state, state_nxt;
  logic [2:0]    cnt;
  logic          is_final;
  logic          pad_pending;
  logic [31:0]   wdog;
  logic          waiting;
  logic          wdog_expire;
  logic          accept;
  logic          core_idle;

  logic [63:0]   pk_blk;
  logic          pk_done;
  logic          pk_final;
  logic          pk_pad;

  ascon_byte_packer #(
    .PAD_BYTE(PAD_BYTE)
  ) u_packer (
    .blk        (blk_data),
    .cnt        (cnt),
    .data       (in_data),
    .last       (in_last),
    .empty      (in_empty),
    .blk_next   (pk_blk),
    .done       (pk_done),
    .final_blk  (pk_final),
    .pad_pending(pk_pad)
  );

  always_comb begin
    in_ready    = (state == S_COLLECT);
    accept      = in_valid && in_ready;
    core_idle   = (core_state == CORE_IDLE);
    waiting     = (state == S_WAIT_IDLE) || (state == S_OFFER) ||
                  (state == S_WAIT_PERM) || (state == S_WAIT_HASH);
    wdog_expire = (WDOG_CYCLES != 0) && waiting && (wdog == WDOG_CYCLES - 1);
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT:   if (accept && pk_done) state_nxt = S_WAIT_IDLE;
      S_PADBLK:    state_nxt = S_WAIT_IDLE;
      S_WAIT_IDLE: if (core_idle) state_nxt = S_OFFER;
      S_OFFER:     if (absorb_done) state_nxt = S_WAIT_PERM;
      S_WAIT_PERM: begin
        if (permutation_done) begin
          if (is_final)         state_nxt = S_WAIT_HASH;
          else if (pad_pending) state_nxt = S_PADBLK;
          else                  state_nxt = S_COLLECT;
        end
      end
      S_WAIT_HASH: if (core_idle) state_nxt = S_COLLECT;
      default:     state_nxt = S_COLLECT;
    endcase
    if (wdog_expire) state_nxt = S_COLLECT;
  end

  // Counts cycles spent in the current core-wait state; restarts on every state change
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog <= '0;
    end else if ((state_nxt != state) || !waiting || (WDOG_CYCLES == 0)) begin
      wdog <= '0;
    end else begin
      wdog <= wdog + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_COLLECT;
      cnt         <= '0;
      blk_data    <= '0;
      is_final    <= 1'b0;
      pad_pending <= 1'b0;
      msg_start   <= 1'b0;
      msg_last    <= 1'b0;
      msg_done    <= 1'b0;
      blk_count   <= '0;
      err         <= 1'b0;
    end else begin
      state    <= state_nxt;
      msg_done <= 1'b0;
      if (msg_done) blk_count <= '0;

      case (state)
        S_COLLECT: begin
          if (accept) begin
            blk_data <= pk_blk;
            cnt      <= cnt + 3'd1;
            if (pk_done) begin
              is_final    <= pk_final;
              pad_pending <= pk_pad;
            end
          end
        end
        S_PADBLK: begin
          blk_data    <= {PAD_BYTE, 56'h0};
          is_final    <= 1'b1;
          pad_pending <= 1'b0;
        end
        S_WAIT_IDLE: begin
          if (core_idle) begin
            msg_start <= 1'b1;
            msg_last  <= is_final;
          end
        end
        S_OFFER: begin
          if (absorb_done) begin
            msg_start <= 1'b0;
            if (blk_count != '1) blk_count <= blk_count + 16'd1;
          end
        end
        S_WAIT_PERM: begin
          if (permutation_done && !is_final && !pad_pending) begin
            cnt      <= '0;
            blk_data <= '0;
          end
        end
        S_WAIT_HASH: begin
          if (core_idle) begin
            msg_done <= 1'b1;
            msg_last <= 1'b0;
            is_final <= 1'b0;
            cnt      <= '0;
            blk_data <= '0;
          end
        end
        default: ;
      endcase

      // Abort wins over any same-cycle handshake: the partial message is dropped
      if (wdog_expire) begin
        err         <= 1'b1;
        msg_start   <= 1'b0;
        msg_last    <= 1'b0;
        cnt         <= '0;
        blk_data    <= '0;
        is_final    <= 1'b0;
        pad_pending <= 1'b0;
        blk_count   <= '0;
      end
    end
  end

endmodule

// File: doc/ascon_msg_feeder.md
Name: ascon_msg_feeder

Overview:
Initiator side of the Ascon-Hash absorb protocol. Accepts a host byte stream and packs it into 64-bit rate blocks with Ascon 10* padding. Drives msg_start/msg_last toward the hash core controller and sequences on its absorb_done, permutation_done and state outputs. Sits between the host/UART byte interface and the Ascon core.

Parameters:
WDOG_CYCLES, 1024, max cycles in any core-wait state before abort; 0 disables the watchdog.
PAD_BYTE, 8'h80, padding marker byte.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  host byte valid
in_ready  out  1  feeder accepts a byte this cycle
in_data  in  8  message byte
in_last  in  1  final byte of message
in_empty  in  1  with in_valid&in_last: zero-length message, in_data ignored
blk_data  out  64  rate block to core; first message byte in [63:56]
msg_start  out  1  block offered / absorb request
msg_last  out  1  current block is final; held through squeeze
absorb_done  in  1  core absorbed blk_data
permutation_done  in  1  core permutation finished
core_state  in  3  core controller state (encodings from ascon_pkg)
msg_done  out  1  one-cycle pulse: digest complete
blk_count  out  16  blocks absorbed for current message, saturating
err  out  1  sticky watchdog abort flag

Behaviour:
- Reset: state COLLECT; blk_data=0, msg_start=0, msg_last=0, msg_done=0, blk_count=0, err=0, byte counter=0, pad_pending=0. in_ready = (state==COLLECT), so it is 1 immediately after reset.
- States: COLLECT, PADBLK, WAIT_IDLE, OFFER, WAIT_PERM, WAIT_HASH.
- COLLECT: a byte is accepted on in_valid&in_ready and written to byte lane cnt (lane 0 = [63:56]); cnt increments.
  - Accept at cnt==7 without in_last: block full, is_final=0 -> WAIT_IDLE.
  - in_last at cnt<7: lane cnt+1 = PAD_BYTE, higher lanes = 0, is_final=1 -> WAIT_IDLE.
  - in_last at cnt==7: block full, is_final=0, pad_pending=1 -> WAIT_IDLE.
  - in_empty&in_last: blk_data = {PAD_BYTE,56'h0}, is_final=1 -> WAIT_IDLE.
  - Latency from the final accepted byte to WAIT_IDLE is one cycle.
- PADBLK: blk_data = {PAD_BYTE,56'h0}, is_final=1, pad_pending cleared -> WAIT_IDLE next cycle.
- WAIT_IDLE: hold until core_state==IDLE (covers the core's post-reset init permutation) -> OFFER.
- OFFER:
  - msg_start=1, msg_last=is_final; blk_data stable.
  - On the edge where absorb_done=1: msg_start=0, blk_count++ -> WAIT_PERM.
- WAIT_PERM: on permutation_done:
  - is_final -> WAIT_HASH.
  - else pad_pending -> PADBLK.
  - else -> COLLECT, cnt=0, blk_data=0.
- WAIT_HASH: msg_last held 1 while the core alternates PERMUTE/SQUEEZE. On core_state==IDLE: msg_done=1 for one cycle, msg_last=0 -> COLLECT. blk_count is cleared the cycle after msg_done.
- in_ready=0 in every state except COLLECT; in_valid there is ignored. No byte is ever dropped silently.
- Watchdog: per-state counter cleared on every state entry, counting in WAIT_IDLE/OFFER/WAIT_PERM/WAIT_HASH. At WDOG_CYCLES-1:
  - err=1 (cleared only by reset); msg_start=0, msg_last=0.
  - Partial message discarded, cnt=0, pad_pending=0, blk_count=0 -> COLLECT.
- absorb_done or permutation_done arriving outside its wait state is ignored.
- Reset mid-operation: all outputs return to reset values asynchronously. The core is reset by the same rst_n.

Decomposition:
- ascon_pkg: core state encodings (INIT=0, IDLE=1, ABSORB=2, PERMUTE=3, SQUEEZE=4), RATE_BYTES=8, PAD_BYTE default, and the feeder state enum typedef.
- One natural sub-module: ascon_byte_packer (byte-lane insert, padding, full/last detection), leaving the FSM and watchdog in the top.

Test Plan:
- "abc" (0x61,0x62,0x63, last on 0x63) -> one OFFER with blk_data=0x6162638000000000, msg_last=1; msg_done once core returns to IDLE; blk_count=1.
- Bytes 0x01..0x08, last on 0x08 -> block 0x0102030405060708 with msg_last=0, then 0x8000000000000000 with msg_last=1; blk_count=2 at msg_done.
- Zero-length message (in_empty&in_last) -> single block 0x8000000000000000, msg_last=1; msg_done follows.
- 9 bytes 0x01..0x09 -> 0x0102030405060708 non-final, then 0x0980000000000000 final; in_ready=0 from block-full until return to COLLECT.
- Core holds core_state=INIT/PERMUTE for 20 cycles after reset, then absorb_done delayed 5 cycles -> msg_start not asserted before IDLE, then held 5 cycles with blk_data stable and dropped on the absorb_done edge.
- WDOG_CYCLES=16 with absorb_done never asserted -> err=1 and msg_start=0 at cycle 16 of OFFER, in_ready=1 next cycle. Separately, rst_n pulsed mid-OFFER -> all outputs at reset values.
